// File: rtl/redundancy_table_writer.sv
// Write-side table owner for the redundancy checker: MT/ST/mask registers, commit handshake, row clear sweep.
// Optional: define RTW_OOB_CHECK_EN to flag dropped out-of-range writes on err_oob.
module redundancy_table_writer #(
   parameter int RSIZ_WIDTH    = 2,
   parameter int ITER_WIDTH    = 9,
   parameter int DIST_WIDTH    = 7,
   parameter int MAX_LIFM_RSIZ = 3,
   parameter int STEP_RANGE    = 128
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        clear,
   input  logic                                        arm,
   input  logic                                        valid,
   input  logic [ITER_WIDTH-1:0]                       n_ch_it,
   input  logic [ITER_WIDTH-1:0]                       n_src_it,
   input  logic [ITER_WIDTH-1:0]                       n_dest_it,
   input  logic [STEP_RANGE-1:0]                       n_src_mt,
   input  logic [1:0]                                  n_src_st,
   input  logic [1:0]                                  n_dest_st,
   input  logic                                        fl_valid,
   input  logic [ITER_WIDTH-1:0]                       fl_out,
   input  logic                                        nr_valid,
   input  logic [ITER_WIDTH-1:0]                       nr_out,
   output logic                                        enable_wt,
   output logic [MAX_LIFM_RSIZ*STEP_RANGE*STEP_RANGE-1:0] mt_buffer,
   output logic [MAX_LIFM_RSIZ*STEP_RANGE*2-1:0]       st_buffer,
   output logic [MAX_LIFM_RSIZ*STEP_RANGE-1:0]         fl_mask,
   output logic [MAX_LIFM_RSIZ*STEP_RANGE-1:0]         nr_mask,
   output logic [ITER_WIDTH:0]                         commit_cnt,
   output logic                                        busy,
   output logic                                        err_oob,
   output logic [2:0]                                  state_dbg
);

   // Handshake: the checker holds valid until it sees enable_wt drop; one commit per valid assertion.
   localparam int NENT  = MAX_LIFM_RSIZ * STEP_RANGE;
   localparam int ROW_W = ITER_WIDTH - DIST_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_COMMIT, S_RELEASE, S_CLEAR} state_t;

   state_t                  state, state_nx;
   logic [ROW_W-1:0]        row_cnt;
   logic [STEP_RANGE-1:0]   mt_q [NENT];
   logic [1:0]              st_q [NENT];
   logic [NENT-1:0]         fl_q, nr_q;
   logic                    do_commit, last_row;

   function automatic logic row_ok(input logic [ITER_WIDTH-1:0] it);
      return int'(it[ITER_WIDTH-1:DIST_WIDTH]) < MAX_LIFM_RSIZ;
   endfunction

   function automatic int ent(input logic [ITER_WIDTH-1:0] it);
      return int'(it[ITER_WIDTH-1:DIST_WIDTH]) * STEP_RANGE + int'(it[DIST_WIDTH-1:0]);
   endfunction

   assign do_commit = (state == S_COMMIT);
   assign last_row  = (state == S_CLEAR) && (int'(row_cnt) == MAX_LIFM_RSIZ - 1);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      enable_wt = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (clear)    state_nx = S_CLEAR;
            else if (arm) state_nx = S_ARMED;
         end
         S_ARMED: begin
            enable_wt = 1'b1;
            if (clear)      state_nx = S_CLEAR;
            else if (valid) state_nx = S_COMMIT;
            else if (!arm)  state_nx = S_IDLE;
         end
         S_COMMIT: state_nx = S_RELEASE;
         S_RELEASE: begin
            if (!valid) state_nx = arm ? S_ARMED : S_IDLE;
         end
         S_CLEAR: begin
            busy = 1'b1;
            if (last_row) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                row_cnt <= '0;
      else if (state != S_CLEAR)   row_cnt <= '0;
      else if (!last_row)          row_cnt <= row_cnt + 1'b1;
   end

   // Per-entry update: clear of the current sweep row, otherwise commit writes.
   // The destination ST write is ordered after the source write so it wins on collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < NENT; e++) begin
            mt_q[e] <= '0;
            st_q[e] <= '0;
         end
         fl_q <= '0;
         nr_q <= '0;
      end else begin
         for (int e = 0; e < NENT; e++) begin
            if (state == S_CLEAR && (e / STEP_RANGE) == int'(row_cnt)) begin
               mt_q[e] <= '0;
               st_q[e] <= '0;
               fl_q[e] <= 1'b0;
               nr_q[e] <= 1'b0;
            end else if (do_commit) begin
               if (row_ok(n_ch_it) && e == ent(n_ch_it))   mt_q[e] <= n_src_mt;
               if (row_ok(n_src_it) && e == ent(n_src_it)) st_q[e] <= n_src_st;
               if (fl_valid && row_ok(n_dest_it) && e == ent(n_dest_it)) st_q[e] <= n_dest_st;
               if (fl_valid && row_ok(fl_out) && e == ent(fl_out))       fl_q[e] <= 1'b1;
               if (nr_valid && row_ok(nr_out) && e == ent(nr_out))       nr_q[e] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         commit_cnt <= '0;
      else if (last_row)                    commit_cnt <= '0;
      else if (do_commit && !(&commit_cnt)) commit_cnt <= commit_cnt + 1'b1;
   end

`ifdef RTW_OOB_CHECK_EN
   logic oob_hit, err_q;
   assign oob_hit = do_commit && (!row_ok(n_ch_it) || !row_ok(n_src_it) ||
                    (fl_valid && (!row_ok(n_dest_it) || !row_ok(fl_out))) ||
                    (nr_valid && !row_ok(nr_out)));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     err_q <= 1'b0;
      else if (last_row) err_q <= 1'b0;
      else if (oob_hit)  err_q <= 1'b1;
   end
   assign err_oob = err_q;
`else
   assign err_oob = 1'b0;
`endif

   for (genvar g = 0; g < NENT; g++) begin : g_flat
      assign mt_buffer[STEP_RANGE*g +: STEP_RANGE] = mt_q[g];
      assign st_buffer[2*g +: 2]                   = st_q[g];
   end
   assign fl_mask = fl_q;
   assign nr_mask = nr_q;

endmodule
